// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing a single-ported byte cache between two requesters.
// One access per grant; sequences write/read/oe, address_bus and the tri-state data_bus.
module cache_port_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned WRITE_CYC = 4,
  parameter int unsigned READ_LAT  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              hit0,
  output logic              hit1,
  output logic              busy,
  output logic              write,
  output logic              read,
  output logic              oe,
  output logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  input  logic              hit
);

  if (WRITE_CYC < 1 || WRITE_CYC > 15) begin : gen_bad_write_cyc
    $error("WRITE_CYC must be in 1..15");
  end
  if (READ_LAT < 1 || READ_LAT > 15) begin : gen_bad_read_lat
    $error("READ_LAT must be in 1..15");
  end

  localparam logic [3:0] WrLast = 4'(WRITE_CYC - 1);
  localparam logic [3:0] RdLast = 4'(READ_LAT - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StWrite, StRead, StResp} state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                hit0_q, hit0_d, hit1_q, hit1_d;
  logic                pick;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    hit0_d   = hit0_q;
    hit1_d   = hit1_q;
    pick     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          pick    = (req0 && req1) ? ~last_q : req1;
          sel_d   = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = we_q ? StWrite : StRead;
      end
      StWrite: begin
        if (cnt_q == WrLast) state_d = StResp;
        else                 cnt_d   = cnt_q + 4'd1;
      end
      StRead: begin
        if (cnt_q == RdLast) begin
          if (sel_q) begin
            rdata1_d = data_bus;
            hit1_d   = hit;
          end else begin
            rdata0_d = data_bus;
            hit0_d   = hit;
          end
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        last_d  = sel_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
      hit0_q   <= 1'b0;
      hit1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      hit0_q   <= hit0_d;
      hit1_q   <= hit1_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign grant0      = (state_q == StSetup) && !sel_q;
  assign grant1      = (state_q == StSetup) &&  sel_q;
  assign done0       = (state_q == StResp)  && !sel_q;
  assign done1       = (state_q == StResp)  &&  sel_q;
  assign write       = (state_q == StWrite);
  assign read        = (state_q == StRead);
  assign oe          = (state_q == StRead);
  assign address_bus = addr_q;
  assign data_bus    = (state_q == StWrite) ? wdata_q : {DATA_W{1'bz}};
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign hit0        = hit0_q;
  assign hit1        = hit1_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: a small cache model on the bus plus per-port scoreboards
// whose entries are pushed when a request is issued and popped on the matching done.
module tb_cache_port_arbiter;

  localparam int WrLat = 5;
  localparam int RdLat = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        grant0, grant1, done0, done1, hit0, hit1;
  logic [7:0]  rdata0, rdata1;
  logic        busy, write, read, oe, cache_hit;
  logic [15:0] address_bus;
  wire  [7:0]  data_bus;

  always #5 clock = ~clock;

  cache_port_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .hit0(hit0), .hit1(hit1),
    .busy(busy), .write(write), .read(read), .oe(oe),
    .address_bus(address_bus), .data_bus(data_bus), .hit(cache_hit)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        hit;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  cyc      = 0;
  int  glog[$];
  int  gcyc[$];
  int  g1_cnt   = 0;
  int  gc0 = 0, gc1 = 0;
  int  wr_run = 0, rd_run = 0;
  logic [15:0] act_addr  = '0;
  logic [7:0]  act_wdata = '0;

  // Cache model seen by the DUT, and the bench's own reference of what should be stored.
  bit [7:0] cmem[256];
  bit       cval[256];
  bit [7:0] rmem[256];
  bit       rval[256];

  assign data_bus  = oe ? cmem[address_bus[7:0]] : 8'hzz;
  assign cache_hit = oe & cval[address_bus[7:0]];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (write) begin
      cmem[address_bus[7:0]] <= data_bus;
      cval[address_bus[7:0]] <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  always @(negedge clock) begin
    sb_t e;
    if (reset) begin
      wr_run = 0;
      rd_run = 0;
    end else begin
      check_eq("wr_rd_excl", 32'(write & read), 32'd0);
      check_eq("oe_eq_read", 32'(oe), 32'(read));
      if (!oe && !write) check_eq("bus_float", 32'(data_bus === 8'hzz), 32'd1);
      if (grant0) begin
        glog.push_back(0);
        gcyc.push_back(cyc);
        gc0 = cyc;
        check_eq("grant0_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          act_addr  = q0[0].addr;
          act_wdata = q0[0].wdata;
        end
      end
      if (grant1) begin
        glog.push_back(1);
        gcyc.push_back(cyc);
        gc1 = cyc;
        g1_cnt++;
        check_eq("grant1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          act_addr  = q1[0].addr;
          act_wdata = q1[0].wdata;
        end
      end
      if (busy) check_eq("addr_stable", 32'(address_bus), 32'(act_addr));
      if (write) begin
        wr_run++;
        check_eq("wr_data", 32'(data_bus), 32'(act_wdata));
      end else if (wr_run != 0) begin
        check_eq("write_len", 32'(wr_run), 32'd4);
        wr_run = 0;
      end
      if (read) rd_run++;
      else if (rd_run != 0) begin
        check_eq("read_len", 32'(rd_run), 32'd2);
        rd_run = 0;
      end
      if (done0) begin
        check_eq("done0_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check_eq("lat0", 32'(cyc - gc0), 32'(e.we ? WrLat : RdLat));
          if (!e.we) begin
            check_eq("rdata0", 32'(rdata0), 32'(e.rdata));
            check_eq("hit0", 32'(hit0), 32'(e.hit));
          end
        end
      end
      if (done1) begin
        check_eq("done1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check_eq("lat1", 32'(cyc - gc1), 32'(e.we ? WrLat : RdLat));
          if (!e.we) begin
            check_eq("rdata1", 32'(rdata1), 32'(e.rdata));
            check_eq("hit1", 32'(hit1), 32'(e.hit));
          end
        end
      end
    end
  end

  function automatic sb_t make_entry(input logic w, input logic [15:0] a, input logic [7:0] d);
    sb_t e;
    e.we    = w;
    e.addr  = a;
    e.wdata = w ? d : 8'h00;
    e.rdata = rmem[a[7:0]];
    e.hit   = rval[a[7:0]];
    if (w) begin
      rmem[a[7:0]] = d;
      rval[a[7:0]] = 1'b1;
    end
    return e;
  endfunction

  // Issue one access on port p; call at a negedge. Returns cycles until grant was seen.
  task automatic do_req(input int p, input logic w, input logic [15:0] a, input logic [7:0] d,
                        output int gw);
    bit seen = 0;
    if (p == 0) begin
      q0.push_back(make_entry(w, a, d));
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      q1.push_back(make_entry(w, a, d));
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    gw = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      gw++;
      seen = (p == 0) ? grant0 : grant1;
    end
    check_eq(p == 0 ? "grant0_seen" : "grant1_seen", 32'(seen), 32'd1);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      seen = (p == 0) ? done0 : done1;
    end
    check_eq(p == 0 ? "done0_seen" : "done1_seen", 32'(seen), 32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clock);
    q0.delete();
    q1.delete();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  gw, gwa, gwb;
    bit  seen;
    bit [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;

    apply_reset();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_strobes", 32'({write, read, oe}), 32'd0);
    check_eq("rst_addr", 32'(address_bus), 32'd0);
    check_eq("rst_pulses", 32'({grant0, grant1, done0, done1}), 32'd0);
    check_eq("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
    check_eq("rst_hits", 32'({hit0, hit1}), 32'd0);
    check_eq("rst_bus_z", 32'(data_bus === 8'hzz), 32'd1);

    // Write then read back through the other port.
    do_req(0, 1'b1, 16'h0001, 8'hFF, gw);
    check_eq("t1_grant_lat", 32'(gw), 32'd1);
    do_req(1, 1'b0, 16'h0001, 8'h00, gw);

    // req0 held high across three writes: grants spaced WRITE_CYC+3 apart.
    glog.delete();
    gcyc.delete();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      wdata0 = vals[i];
      q0.push_back(make_entry(1'b1, 16'h0001, vals[i]));
      seen = 0;
      for (int k = 0; k < 60 && !seen; k++) begin
        @(negedge clock);
        seen = grant0;
      end
      check_eq("t4_grant_seen", 32'(seen), 32'd1);
    end
    req0 = 1'b0;
    repeat (8) @(negedge clock);
    check_eq("t4_ngrants", 32'(gcyc.size()), 32'd3);
    if (gcyc.size() == 3) begin
      check_eq("t4_space1", 32'(gcyc[1] - gcyc[0]), 32'd7);
      check_eq("t4_space2", 32'(gcyc[2] - gcyc[1]), 32'd7);
    end
    do_req(0, 1'b0, 16'h0001, 8'h00, gw);

    // Reset in the second WRITE cycle: no done, outputs cleared.
    q0.push_back(make_entry(1'b1, 16'h0040, 8'h5A));
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0040; wdata0 = 8'h5A;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clock);
      seen = grant0;
    end
    check_eq("t5_grant_seen", 32'(seen), 32'd1);
    req0 = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("t5_in_write", 32'(write), 32'd1);
    reset = 1'b1;
    q0.delete();
    @(negedge clock);
    check_eq("t5_write_drop", 32'(write), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_bus_z", 32'(data_bus === 8'hzz), 32'd1);
    check_eq("t5_rdata0", 32'(rdata0), 32'd0);
    check_eq("t5_done0", 32'(done0), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    // One-cycle req1 pulse while busy must be ignored.
    gwa = g1_cnt;
    fork
      do_req(0, 1'b1, 16'h0050, 8'hA5, gw);
      begin
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
          @(negedge clock);
          seen = grant0;
        end
        @(negedge clock);
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0001;
        @(negedge clock);
        req1 = 1'b0;
      end
    join
    repeat (12) @(negedge clock);
    check_eq("t6_no_grant1", 32'(g1_cnt), 32'(gwa));

    // Ties after reset alternate starting with req0; includes a cache miss.
    apply_reset();
    glog.delete();
    fork
      begin
        do_req(0, 1'b1, 16'h0010, 8'h10, gwa);
        do_req(0, 1'b1, 16'h0011, 8'h11, gwa);
      end
      begin
        do_req(1, 1'b0, 16'h0001, 8'h00, gwb);
        do_req(1, 1'b0, 16'h0080, 8'h00, gwb);
      end
    join
    check_eq("t3_ngrants", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      check_eq("t3_order0", 32'(glog[0]), 32'd0);
      check_eq("t3_order1", 32'(glog[1]), 32'd1);
      check_eq("t3_order2", 32'(glog[2]), 32'd0);
      check_eq("t3_order3", 32'(glog[3]), 32'd1);
    end
    do_req(1, 1'b0, 16'h0011, 8'h00, gw);
    repeat (4) @(negedge clock);
    check_eq("sb0_empty", 32'(q0.size()), 32'd0);
    check_eq("sb1_empty", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
